// File: rtl/ia_sparse_packer.sv
// Zero-skipping packer: turns one dense activation pixel into the compressed IA bundle for the PE.
// Optional feature macro IA_SPARSE_THRESH_EN adds i_thresh and drops values with |x| <= i_thresh.
module ia_sparse_packer #(
    parameter int IA_CHANNEL = 32,
    parameter int DATA_W     = 16,
    parameter int C_W        = 8,
    parameter int POS_W      = 8,
    parameter int AIM_WIDTH  = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic [POS_W-1:0]                     i_h,
    input  logic [POS_W-1:0]                     i_w,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic signed [DATA_W-1:0]             i_data,
    input  logic                                 i_last,
`ifdef IA_SPARSE_THRESH_EN
    input  logic [DATA_W-2:0]                    i_thresh,
`endif
    input  logic                                 i_consume,
    output logic                                 o_done,
    output logic [POS_W-1:0]                     o_ia_h,
    output logic [POS_W-1:0]                     o_ia_w,
    output logic [IA_CHANNEL-1:0][DATA_W-1:0]    o_ia_data,
    output logic [IA_CHANNEL-1:0][C_W-1:0]       o_ia_c_idx,
    output logic [$clog2(IA_CHANNEL):0]          o_ia_len,
    output logic [$clog2(IA_CHANNEL):0]          o_ia_iters
);

    localparam int LEN_W = $clog2(IA_CHANNEL) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] chan_cnt;
    logic             accept;
    logic             final_beat;
    logic             keep;
    logic [LEN_W-1:0] len_next;

    // ceil(n / AIM_WIDTH) - 1, with an empty bundle still needing one (zero) iteration
    function automatic logic [LEN_W-1:0] iters_of(input logic [LEN_W-1:0] n);
        if (n == '0) begin
            return '0;
        end
        return LEN_W'((32'(n) - 32'd1) / AIM_WIDTH);
    endfunction

    assign o_ready    = (state == COLLECT);
    assign o_done     = (state == HOLD);
    assign accept     = i_valid && o_ready;
    assign final_beat = accept && (i_last || (chan_cnt == LEN_W'(IA_CHANNEL - 1)));
    assign len_next   = o_ia_len + LEN_W'(keep);

`ifdef IA_SPARSE_THRESH_EN
    logic [DATA_W-1:0] magnitude;
    logic              is_most_negative;

    // The most negative code has no positive twin, so it is treated as saturated and always kept
    always_comb begin
        is_most_negative = (i_data == {1'b1, {(DATA_W - 1){1'b0}}});
        magnitude        = i_data[DATA_W-1] ? $unsigned(-i_data) : $unsigned(i_data);
        keep             = is_most_negative || (magnitude[DATA_W-2:0] > i_thresh);
    end
`else
    always_comb begin
        keep = (i_data != '0);
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)    state_next = COLLECT;
            COLLECT: if (final_beat) state_next = HOLD;
            HOLD:    if (i_consume)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Bundle registers change only on pixel start and on accepted beats, so they stay frozen in HOLD
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ia_h     <= '0;
            o_ia_w     <= '0;
            o_ia_data  <= '0;
            o_ia_c_idx <= '0;
            o_ia_len   <= '0;
            o_ia_iters <= '0;
            chan_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_ia_h     <= i_h;
                        o_ia_w     <= i_w;
                        o_ia_data  <= '0;
                        o_ia_c_idx <= '0;
                        o_ia_len   <= '0;
                        o_ia_iters <= '0;
                        chan_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (keep) begin
                            for (int i = 0; i < IA_CHANNEL; i++) begin
                                if (o_ia_len == LEN_W'(i)) begin
                                    o_ia_data[i]  <= i_data;
                                    o_ia_c_idx[i] <= C_W'(chan_cnt);
                                end
                            end
                        end
                        o_ia_len <= len_next;
                        chan_cnt <= chan_cnt + LEN_W'(1);
                        if (final_beat) begin
                            o_ia_iters <= iters_of(len_next);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
